// File: rtl/muldiv_sequencer_if.sv
// Bus between the decode/datapath side and the multiply/divide sequencer.
// The datapath (master) presents the decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
// request with its operands. The sequencer (slave) returns architectural HI/LO,
// busy, the combinational stall and the one-cycle done pulse.
//   start    decoded MULT/MULTU/DIV/DIVU this cycle
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     rs / rt operand values
//   hilo_rd  MFHI or MFLO decoded this cycle
//   mthi     MTHI decoded this cycle
//   mtlo     MTLO decoded this cycle
//   wdata    rs value for MTHI/MTLO
//   hi, lo   architectural HI/LO
//   busy     an operation is in flight
//   stall    hold the PC/regfile path
//   done     HI/LO were just written by an operation
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hilo_rd;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             stall;
   logic             done;

   modport master (
      output start, op, a, b, hilo_rd, mthi, mtlo, wdata,
      input  hi, lo, busy, stall, done
   );

   modport slave (
      input  start, op, a, b, hilo_rd, mthi, mtlo, wdata,
      output hi, lo, busy, stall, done
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller and owner of the HI/LO registers.
// Signed operations run an unsigned core on operand magnitudes and fix the sign
// on the final write. One iteration per enabled clock, WIDTH iterations, so
// HI/LO become valid WIDTH+1 enabled edges after the start edge.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low; clears all state including HI/LO
//   clk_enable  0 freezes every register (state, counter, HI/LO, done)
//   bus         slave side of muldiv_sequencer_if (request, operands, HI/LO, busy/stall/done)
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clk_enable,
   muldiv_sequencer_if.slave    bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      CALC   = 2'b01,
      FINISH = 2'b10
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CW-1:0]      count;
   logic               is_div;
   logic               res_neg;
   logic               rem_neg;
   logic               div_zero;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;

   logic               op_signed;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_fits;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Operand magnitudes for the unsigned core. op[0]=0 selects the signed forms.
   always_comb begin
      op_signed = ~bus.op[0];
      a_neg     = op_signed & bus.a[WIDTH-1];
      b_neg     = op_signed & bus.b[WIDTH-1];
      a_mag     = a_neg ? -bus.a : bus.a;
      b_mag     = b_neg ? -bus.b : bus.b;
   end

   // One iteration of each core. Multiply: the multiplier sits in the low half of
   // prod and is consumed LSB first while the partial sum enters from the top.
   // Divide: the dividend sits in the low half of prod and is shifted out MSB first
   // into the remainder while quotient bits are shifted in at the bottom. The
   // shifted remainder needs WIDTH+1 bits; after a successful subtract it always
   // fits back into WIDTH bits.
   always_comb begin
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
      div_shift = {rem, prod[WIDTH-1]};
      div_fits  = (div_shift >= {1'b0, opnd});
      div_diff  = div_shift[WIDTH-1:0] - opnd;
   end

   // Sign fixup applied on the final write. A zero divisor skips quotient fixup so
   // the quotient is always all-ones; the remainder then equals the dividend.
   always_comb begin
      prod_fix = res_neg ? -prod : prod;
      quo_fix  = div_zero ? '1 : (res_neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0]);
      rem_fix  = rem_neg ? -rem : rem;
   end

   // State register; frozen while clk_enable is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else if (clk_enable) begin
         state <= state_next;
      end
   end

   // Next-state logic: IDLE -> CALC on start, CALC for WIDTH iterations, then a
   // single FINISH cycle that writes HI/LO. Unused encodings fall back to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = CALC;
         CALC:    if (count == CW'(WIDTH-1)) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and HI/LO. In IDLE a start latches operands and wins over MTHI/MTLO;
   // HI/LO are only touched in IDLE (moves) or FINISH (result), never mid-operation.
   // done is a pulse: it is cleared on every enabled edge except the FINISH edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         is_div   <= 1'b0;
         res_neg  <= 1'b0;
         rem_neg  <= 1'b0;
         div_zero <= 1'b0;
         opnd     <= '0;
         prod     <= '0;
         rem      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else if (clk_enable) begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  count    <= '0;
                  is_div   <= bus.op[1];
                  res_neg  <= a_neg ^ b_neg;
                  rem_neg  <= a_neg;
                  div_zero <= (bus.b == '0);
                  rem      <= '0;
                  if (bus.op[1]) begin
                     opnd <= b_mag;
                     prod <= {{WIDTH{1'b0}}, a_mag};
                  end else begin
                     opnd <= a_mag;
                     prod <= {{WIDTH{1'b0}}, b_mag};
                  end
               end else begin
                  if (bus.mthi) hi_q <= bus.wdata;
                  if (bus.mtlo) lo_q <= bus.wdata;
               end
            end
            CALC: begin
               count <= count + CW'(1);
               if (is_div) begin
                  rem              <= div_fits ? div_diff : div_shift[WIDTH-1:0];
                  prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], div_fits};
               end else begin
                  prod <= {mul_sum, prod[WIDTH-1:1]};
               end
            end
            FINISH: begin
               if (is_div) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.done  = done_q;
   assign bus.busy  = (state != IDLE);
   assign bus.stall = bus.busy & (bus.start | bus.hilo_rd | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (WIDTH=32).
// A table of directed multiply/divide vectors with hand-computed HI/LO is run
// back to back, followed by hand-written sequences for moves, stalls,
// clk_enable freezing and reset in the middle of an operation.
module tb_muldiv_sequencer;
   localparam int WIDTH = 32;

   logic clk;
   logic reset;
   logic clk_enable;

   muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

   muldiv_sequencer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .bus        (bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t        vecs [12];
   int          checks;
   int          failures;
   logic [31:0] model_hi;
   logic [31:0] model_lo;

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Last-resort time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "[TB] time limit");
   end

   // One comparison: bumps the counters and reports any difference.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge, where outputs are sampled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a multiply/divide request for exactly one edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   // Wait for busy to drop, bounded.
   task automatic waitIdle(output int cycles);
      cycles = 0;
      while (bus.busy && cycles < 200) begin
         cycles++;
         step();
      end
   endtask

   // Full operation: latency, HI/LO held while busy, results, single done pulse.
   task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int busy_cycles;
      bit held;
      busy_cycles = 0;
      held = 1'b1;
      applyStimulus(op, a, b);
      while (bus.busy && busy_cycles < 200) begin
         busy_cycles++;
         if (bus.hi !== model_hi || bus.lo !== model_lo || bus.done !== 1'b0) held = 1'b0;
         step();
      end
      checkOutput($sformatf("%s latency", tag), 64'(busy_cycles), 64'd33);
      checkOutput($sformatf("%s hold", tag), 64'(held), 64'd1);
      checkOutput($sformatf("%s done", tag), 64'(bus.done), 64'd1);
      checkOutput($sformatf("%s hi", tag), 64'(bus.hi), 64'(exp_hi));
      checkOutput($sformatf("%s lo", tag), 64'(bus.lo), 64'(exp_lo));
      model_hi = exp_hi;
      model_lo = exp_lo;
      step();
      checkOutput($sformatf("%s done pulse", tag), 64'(bus.done), 64'd0);
   endtask

   initial begin
      int  n;
      int  en_edges;
      int  iter;
      bit  ok;

      checks   = 0;
      failures = 0;
      model_hi = '0;
      model_lo = '0;

      //            op     a             b             exp_hi        exp_lo
      vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{2'b11, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
      vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[7]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
      vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[9]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      vecs[10] = '{2'b00, 32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC};
      vecs[11] = '{2'b11, 32'h12345678, 32'h00001000, 32'h00000678, 32'h00012345};

      // Reset with requests pending: nothing may start and stall must stay low.
      reset       = 1'b0;
      clk_enable  = 1'b1;
      bus.start   = 1'b1;
      bus.op      = 2'b01;
      bus.a       = 32'd3;
      bus.b       = 32'd3;
      bus.hilo_rd = 1'b1;
      bus.mthi    = 1'b0;
      bus.mtlo    = 1'b0;
      bus.wdata   = '0;
      step();
      step();
      checkOutput("reset hi", 64'(bus.hi), 64'd0);
      checkOutput("reset lo", 64'(bus.lo), 64'd0);
      checkOutput("reset busy", 64'(bus.busy), 64'd0);
      checkOutput("reset done", 64'(bus.done), 64'd0);
      checkOutput("reset stall", 64'(bus.stall), 64'd0);
      bus.start   = 1'b0;
      bus.hilo_rd = 1'b0;
      #3 reset = 1'b1;
      step();

      // Table of directed operations, run back to back.
      for (int i = 0; i < 12; i++) begin
         runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
      end

      // MTHI/MTLO while idle, then MFHI issued during a MULT: stalled until done.
      bus.wdata = 32'h00001234;
      bus.mthi  = 1'b1;
      step();
      bus.mthi  = 1'b0;
      checkOutput("mthi idle", 64'(bus.hi), 64'h1234);
      bus.wdata = 32'h00005678;
      bus.mtlo  = 1'b1;
      step();
      bus.mtlo  = 1'b0;
      checkOutput("mtlo idle", 64'(bus.lo), 64'h5678);
      applyStimulus(2'b00, 32'hFFFFFFFA, 32'd7);
      bus.hilo_rd = 1'b1;
      n  = 0;
      ok = 1'b1;
      while (bus.stall && n < 200) begin
         n++;
         if (bus.hi !== 32'h00001234) ok = 1'b0;
         step();
      end
      checkOutput("mfhi stall cycles", 64'(n), 64'd33);
      checkOutput("mfhi no partial hi", 64'(ok), 64'd1);
      checkOutput("mfhi done at release", 64'(bus.done), 64'd1);
      checkOutput("mfhi sees mult hi", 64'(bus.hi), 64'hFFFFFFFF);
      checkOutput("mfhi sees mult lo", 64'(bus.lo), 64'hFFFFFFD6);
      bus.hilo_rd = 1'b0;
      step();

      // MTHI during a multiply is deferred until the first idle edge.
      applyStimulus(2'b01, 32'd2, 32'd3);
      bus.wdata = 32'h0000AAAA;
      bus.mthi  = 1'b1;
      checkOutput("mthi busy stall", 64'(bus.stall), 64'd1);
      waitIdle(n);
      checkOutput("mthi busy latency", 64'(n), 64'd33);
      checkOutput("mthi busy ignored", 64'(bus.hi), 64'd0);
      checkOutput("mthi stall released", 64'(bus.stall), 64'd0);
      step();
      bus.mthi = 1'b0;
      checkOutput("mthi taken after idle", 64'(bus.hi), 64'hAAAA);
      checkOutput("mthi keeps lo", 64'(bus.lo), 64'd6);

      // start and MTLO on the same idle edge: start wins, LO untouched.
      bus.wdata = 32'h0000DEAD;
      bus.mtlo  = 1'b1;
      applyStimulus(2'b11, 32'd10, 32'd3);
      bus.mtlo  = 1'b0;
      checkOutput("start beats mtlo", 64'(bus.lo), 64'd6);
      waitIdle(n);
      checkOutput("divu 10/3 hi", 64'(bus.hi), 64'd1);
      checkOutput("divu 10/3 lo", 64'(bus.lo), 64'd3);
      step();

      // clk_enable toggling: completion counts enabled edges only; done holds when frozen.
      applyStimulus(2'b00, 32'hFFFFFFFD, 32'd7);
      bus.hilo_rd = 1'b1;
      en_edges = 0;
      iter     = 0;
      ok       = 1'b1;
      while (bus.busy && iter < 400) begin
         iter++;
         clk_enable = ~clk_enable;
         if (bus.stall !== 1'b1) ok = 1'b0;
         step();
         if (clk_enable) en_edges++;
      end
      bus.hilo_rd = 1'b0;
      checkOutput("gated enabled edges", 64'(en_edges), 64'd33);
      checkOutput("gated total edges", 64'(iter), 64'd66);
      checkOutput("gated stall held", 64'(ok), 64'd1);
      checkOutput("gated hi", 64'(bus.hi), 64'hFFFFFFFF);
      checkOutput("gated lo", 64'(bus.lo), 64'hFFFFFFEB);
      clk_enable = 1'b0;
      step();
      step();
      checkOutput("done frozen", 64'(bus.done), 64'd1);
      clk_enable = 1'b1;
      step();
      checkOutput("done clears", 64'(bus.done), 64'd0);

      // Reset low at CALC count 10: abort, HI/LO cleared, no done afterwards.
      applyStimulus(2'b01, 32'h0000FFFF, 32'h0000FFFF);
      repeat (10) step();
      #2 reset = 1'b0;
      #1;
      checkOutput("abort busy", 64'(bus.busy), 64'd0);
      checkOutput("abort hi", 64'(bus.hi), 64'd0);
      checkOutput("abort lo", 64'(bus.lo), 64'd0);
      checkOutput("abort done", 64'(bus.done), 64'd0);
      #3 reset = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (bus.done || bus.busy) ok = 1'b1;
      end
      checkOutput("abort no done", 64'(ok), 64'd0);
      model_hi = '0;
      model_lo = '0;
      runOp("after abort", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
